// File: rtl/instr_emitter.sv
// Sequential WISC instruction encoder: packs symbolic requests into 16-bit words
// and streams them to instruction memory, expanding LDI into an LLB/LHB pair.
module instr_emitter #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned DEPTH     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [3:0]  req_rd,
   input  logic [3:0]  req_rs,
   input  logic [3:0]  req_rt,
   input  logic [2:0]  req_cond,
   input  logic [15:0] req_imm,
   output logic        imem_we,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic [15:0] count,
   output logic        done,
   output logic        err
);

   localparam int unsigned WordW = 16;
   localparam logic [4:0]  OpLdi = 5'h10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EMIT_HI = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic [WordW-1:0]   addr_q, addr_d;
   logic [WordW-1:0]   wdata_q, wdata_d;
   logic [WordW-1:0]   count_q, count_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [3:0]         hold_rd_q, hold_rd_d;
   logic [7:0]         hold_imm_q, hold_imm_d;

   logic               accept;
   logic               has_room;
   logic               room_for_two;
   logic [WordW-1:0]   word_addr;
   logic [WordW-1:0]   native_word;

   assign has_room     = 32'(count_q) < DEPTH;
   assign room_for_two = (32'(count_q) + 32'd2) <= DEPTH;
   assign req_ready    = rst_n & ~start & (state_q == S_IDLE) & has_room;
   assign accept       = req_valid & req_ready;
   // Byte address of word k; wraps naturally at 16 bits.
   assign word_addr    = BASE_ADDR + {count_q[14:0], 1'b0};

   // Field packing for the sixteen native opcodes.
   always_comb begin
      native_word = 16'h0000;
      unique case (req_op[3:0])
         4'h0, 4'h1, 4'h2, 4'h3, 4'h7:
            native_word = {req_op[3:0], req_rd, req_rs, req_rt};
         4'h4, 4'h5, 4'h6, 4'h8, 4'h9:
            native_word = {req_op[3:0], req_rd, req_rs, req_imm[3:0]};
         4'hA, 4'hB:
            native_word = {req_op[3:0], req_rd, req_imm[7:0]};
         4'hC:
            native_word = {req_op[3:0], req_cond, req_imm[8:0]};
         4'hD:
            native_word = {req_op[3:0], req_cond, 1'b0, req_rs, 4'h0};
         4'hE:
            native_word = {req_op[3:0], req_rd, 8'h00};
         default:
            native_word = 16'hF000;
      endcase
   end

   // Next-state and output computation.
   always_comb begin
      state_d    = state_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      count_d    = count_q;
      done_d     = done_q;
      err_d      = err_q;
      hold_rd_d  = hold_rd_q;
      hold_imm_d = hold_imm_q;

      if (start) begin
         state_d = S_IDLE;
         count_d = 16'h0000;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (!req_op[4]) begin
                     we_d    = 1'b1;
                     addr_d  = word_addr;
                     wdata_d = native_word;
                     count_d = count_q + 16'd1;
                     if (req_op[3:0] == 4'hF) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                     end
                  end else if (req_op == OpLdi && room_for_two) begin
                     we_d       = 1'b1;
                     addr_d     = word_addr;
                     wdata_d    = {4'hA, req_rd, req_imm[7:0]};
                     count_d    = count_q + 16'd1;
                     hold_rd_d  = req_rd;
                     hold_imm_d = req_imm[15:8];
                     state_d    = S_EMIT_HI;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_EMIT_HI: begin
               we_d    = 1'b1;
               addr_d  = word_addr;
               wdata_d = {4'hB, hold_rd_q, hold_imm_q};
               count_d = count_q + 16'd1;
               state_d = S_IDLE;
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 16'h0000;
         count_q    <= 16'h0000;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         hold_rd_q  <= 4'h0;
         hold_imm_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         count_q    <= count_d;
         done_q     <= done_d;
         err_q      <= err_d;
         hold_rd_q  <= hold_rd_d;
         hold_imm_q <= hold_imm_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_emitter.sv
// Scoreboard bench for instr_emitter: a reference model predicts each memory write,
// a separate monitor checks the write port and status flags every cycle.
module tb_instr_emitter;

   localparam logic [15:0] BASE  = 16'hFFFC;
   localparam int unsigned DEPTH = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'h0;
   logic [3:0]  req_rd = 4'h0, req_rs = 4'h0, req_rt = 4'h0;
   logic [2:0]  req_cond = 3'h0;
   logic [15:0] req_imm = 16'h0;
   logic        imem_we;
   logic [15:0] imem_addr, imem_wdata, count;
   logic        done, err;

   instr_emitter #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
      .req_cond(req_cond), .req_imm(req_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   // Reference model state
   int          m_count = 0;
   bit          m_done = 0, m_err = 0, m_pend = 0;
   logic [15:0] m_hi_word;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [2:0] cond, input logic [15:0] imm);
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h7: return {op, rd, rs, rt};
         4'h4, 4'h5, 4'h6, 4'h8, 4'h9: return {op, rd, rs, imm[3:0]};
         4'hA, 4'hB:                   return {op, rd, imm[7:0]};
         4'hC:                         return {op, cond, imm[8:0]};
         4'hD:                         return {op, cond, 1'b0, rs, 4'h0};
         4'hE:                         return {op, rd, 8'h00};
         default:                      return 16'hF000;
      endcase
   endfunction

   function automatic logic [15:0] addr_of(input int k);
      return 16'(int'(BASE) + 2 * k);
   endfunction

   function automatic void push_word(input logic [15:0] w);
      wr_t e;
      e.addr = addr_of(m_count);
      e.data = w;
      exp_q.push_back(e);
      m_count++;
   endfunction

   // One clock of stimulus plus the model's view of what that edge does.
   task automatic step(input bit v, input logic [4:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt, input logic [2:0] cond,
                       input logic [15:0] imm, input bit st, input bit rst);
      bit exp_ready, acc;
      @(negedge clk);
      rst_n = ~rst; start = st; req_valid = v;
      req_op = op; req_rd = rd; req_rs = rs; req_rt = rt; req_cond = cond; req_imm = imm;
      #1;
      exp_ready = !rst && !st && !m_pend && !m_done && (m_count < DEPTH);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      acc = v && exp_ready;
      @(posedge clk);
      if (rst || st) begin
         m_count = 0; m_done = 0; m_err = 0; m_pend = 0;
      end else if (m_pend) begin
         push_word(m_hi_word);
         m_pend = 0;
      end else if (acc) begin
         if (op < 5'h10) begin
            push_word(enc(op[3:0], rd, rs, rt, cond, imm));
            if (op == 5'h0F) m_done = 1;
         end else if (op == 5'h10 && m_count + 2 <= DEPTH) begin
            push_word({4'hA, rd, imm[7:0]});
            m_hi_word = {4'hB, rd, imm[15:8]};
            m_pend = 1;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic op_step(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [2:0] cond, input logic [15:0] imm);
      step(1'b1, op, rd, rs, rt, cond, imm, 1'b0, 1'b0);
   endtask

   task automatic idle_step(input bit st, input bit rst);
      step(1'b0, 5'h0, 4'h0, 4'h0, 4'h0, 3'h0, 16'h0, st, rst);
   endtask

   task automatic rnd_step();
      int r;
      logic [4:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 70)      op = 5'(  $urandom_range(0, 14));
      else if (r < 75) op = 5'h0F;
      else if (r < 93) op = 5'h10;
      else             op = 5'(  $urandom_range(17, 31));
      step(($urandom_range(0, 99) < 75), op, 4'($urandom), 4'($urandom), 4'($urandom),
           3'($urandom), 16'($urandom), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 199) == 0));
   endtask

   // Monitor: each cycle the write port must match the head of the expected queue.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_we", 32'(imem_we), 32'd1);
            chk("imem_addr", 32'(imem_addr), 32'(e.addr));
            chk("imem_wdata", 32'(imem_wdata), 32'(e.data));
         end else begin
            chk("imem_we_idle", 32'(imem_we), 32'd0);
         end
         chk("count", 32'(count), 32'(m_count));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
      end
   end

   initial begin
      idle_step(1'b0, 1'b1);
      idle_step(1'b0, 1'b1);
      // add, LDI, b, br, sll fill the 6-word program; pcs then stalls
      op_step(5'h00, 4'd1, 4'd2, 4'd3, 3'd0, 16'h0000);
      op_step(5'h10, 4'd5, 4'd0, 4'd0, 3'd0, 16'hBEEF);
      op_step(5'h10, 4'd5, 4'd0, 4'd0, 3'd0, 16'hBEEF);
      op_step(5'h0C, 4'd0, 4'd0, 4'd0, 3'd3, 16'h01F0);
      op_step(5'h0D, 4'd0, 4'd4, 4'd0, 3'd7, 16'h0000);
      op_step(5'h04, 4'd2, 4'd2, 4'd0, 3'd0, 16'h0004);
      op_step(5'h0E, 4'd9, 4'd0, 4'd0, 3'd0, 16'h0000);
      op_step(5'h0E, 4'd9, 4'd0, 4'd0, 3'd0, 16'h0000);
      idle_step(1'b1, 1'b0);
      // LDI with one slot left is rejected, then the last slot is filled
      for (int i = 0; i < 5; i++) op_step(5'h01, 4'(i), 4'd3, 4'd7, 3'd0, 16'h0);
      op_step(5'h10, 4'd6, 4'd0, 4'd0, 3'd0, 16'h1234);
      op_step(5'h00, 4'd1, 4'd1, 4'd1, 3'd0, 16'h0);
      op_step(5'h00, 4'd2, 4'd2, 4'd2, 3'd0, 16'h0);
      idle_step(1'b1, 1'b0);
      // HLT then stalled request, restart at base
      op_step(5'h0F, 4'd0, 4'd0, 4'd0, 3'd0, 16'h0);
      op_step(5'h00, 4'd3, 4'd3, 4'd3, 3'd0, 16'h0);
      idle_step(1'b1, 1'b0);
      op_step(5'h07, 4'd4, 4'd5, 4'd6, 3'd0, 16'h0);
      // start and reset landing on the pending LHB cycle
      op_step(5'h10, 4'd7, 4'd0, 4'd0, 3'd0, 16'hCAFE);
      idle_step(1'b1, 1'b0);
      op_step(5'h10, 4'd8, 4'd0, 4'd0, 3'd0, 16'hF00D);
      idle_step(1'b0, 1'b1);
      // illegal op flags err but leaves the port ready
      op_step(5'h13, 4'd0, 4'd0, 4'd0, 3'd0, 16'h0);
      op_step(5'h08, 4'd1, 4'd2, 4'd0, 3'd0, 16'h000C);
      idle_step(1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) rnd_step();
      idle_step(1'b0, 1'b0);
      idle_step(1'b0, 1'b0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
